inst_axi_rd_bridge: RTL

Read-only bridge between the IF stage's SRAM-like instruction port and the AXI3 read channels (AR/R) of the core's bus interface. Accepts one address per `inst_sram_req`/`inst_sram_addr_ok` handshake and returns the instruction word with `inst_sram_data_ok`. Tracks up to `MAX_OUTSTANDING` in-flight reads in order. It sits directly upstream of the IF stage and serves its fetch requests.

---
 rtl/inst_axi_rd_bridge.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/inst_axi_rd_bridge.sv
// inst_axi_rd_bridge
//   Read-only bridge from the IF stage's SRAM-like instruction port to the
//   AXI3 AR/R channels. Accepts one fetch address per AR handshake and
//   returns the fetched words in the order their addresses were issued.
//   Up to MAX_OUTSTANDING reads may be in flight at once.
//
// Parameters
//   ARID            fixed AXI ID for every read; R beats with another ID are
//                   accepted and discarded
//   MAX_OUTSTANDING accepted-but-unreturned read limit (1..7)
//
// Ports
//   clk, reset          single clock, synchronous active-high reset
//   inst_sram_*         IF-side request/response port (wr/wstrb/wdata ignored)
//   ar*                 AXI read-address channel (single-beat INCR bursts)
//   r*                  AXI read-data channel (rresp/rlast ignored)
//
// Build option
//   INST_BRIDGE_RBUF_EN  when defined, R data passes through a one-entry
//                        register, so data_ok trails the R handshake by one
//                        cycle; otherwise R data is forwarded combinationally.

module inst_axi_rd_bridge #(
  parameter logic [3:0] ARID            = 4'd0,
  parameter int         MAX_OUTSTANDING = 2
) (
  input  logic        clk,
  input  logic        reset,

  input  logic        inst_sram_req,
  input  logic        inst_sram_wr,
  input  logic [1:0]  inst_sram_size,
  input  logic [31:0] inst_sram_addr,
  input  logic [3:0]  inst_sram_wstrb,
  input  logic [31:0] inst_sram_wdata,
  output logic        inst_sram_addr_ok,
  output logic        inst_sram_data_ok,
  output logic [31:0] inst_sram_rdata,

  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [7:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  output logic [1:0]  arlock,
  output logic [3:0]  arcache,
  output logic [2:0]  arprot,
  output logic        arvalid,
  input  logic        arready,

  input  logic [3:0]  rid,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rlast,
  input  logic        rvalid,
  output logic        rready
);

  localparam int              CW      = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CW-1:0]   MAX_CNT = CW'(MAX_OUTSTANDING);

  typedef enum logic {
    AR_IDLE = 1'b0,
    AR_BUSY = 1'b1
  } ar_state_e;

  ar_state_e     state_q, state_d;
  logic [31:0]   araddr_q, araddr_d;
  logic [2:0]    arsize_q, arsize_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic ar_hs;
  logic r_hs;

  // Never consumed; collected only so the ignored inputs are not dangling.
  logic unused_inputs;
  assign unused_inputs = ^{inst_sram_wr, inst_sram_wstrb, inst_sram_wdata, rresp, rlast};

  assign arid    = ARID;
  assign araddr  = araddr_q;
  assign arlen   = 8'd0;
  assign arsize  = arsize_q;
  assign arburst = 2'b01;
  assign arlock  = 2'b00;
  assign arcache = 4'b0000;
  assign arprot  = 3'b000;

  assign arvalid           = (state_q == AR_BUSY);
  assign ar_hs             = arvalid & arready;
  assign inst_sram_addr_ok = ar_hs;

  // A matching beat with nothing outstanding can only be a leftover from
  // before a reset, so it is dropped along with foreign-ID beats.
  assign r_hs = rvalid & rready & (rid == ARID) & (cnt_q != '0);

  always_comb begin
    state_d  = state_q;
    araddr_d = araddr_q;
    arsize_d = arsize_q;
    unique case (state_q)
      AR_IDLE: begin
        if (inst_sram_req && (cnt_q < MAX_CNT)) begin
          araddr_d = inst_sram_addr;
          arsize_d = {1'b0, inst_sram_size};
          state_d  = AR_BUSY;
        end
      end
      AR_BUSY: begin
        if (arready) state_d = AR_IDLE;
      end
      default: state_d = AR_IDLE;
    endcase
  end

  always_comb begin
    cnt_d = cnt_q;
    unique case ({ar_hs, r_hs})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= AR_IDLE;
      araddr_q <= 32'd0;
      arsize_q <= 3'd0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      araddr_q <= araddr_d;
      arsize_q <= arsize_d;
      cnt_q    <= cnt_d;
    end
  end

`ifdef INST_BRIDGE_RBUF_EN
  logic        buf_valid_q, buf_valid_d;
  logic [31:0] buf_data_q, buf_data_d;

  // The buffer is presented every cycle it holds data and IF never stalls
  // data_ok, so it can always take a new beat while draining the old one.
  assign rready            = ~buf_valid_q | inst_sram_data_ok;
  assign inst_sram_data_ok = buf_valid_q;
  assign inst_sram_rdata   = buf_data_q;

  always_comb begin
    buf_valid_d = r_hs;
    buf_data_d  = r_hs ? rdata : buf_data_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      buf_valid_q <= 1'b0;
      buf_data_q  <= 32'd0;
    end else begin
      buf_valid_q <= buf_valid_d;
      buf_data_q  <= buf_data_d;
    end
  end
`else
  assign rready            = 1'b1;
  assign inst_sram_data_ok = rvalid & (rid == ARID) & (cnt_q != '0);
  assign inst_sram_rdata   = rdata;
`endif

endmodule
